mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..255.
REQ-002 SHALL have parameter BASE_ADDR, default 8'hF0, data register address; status register is at BASE_ADDR+1.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..16.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low (0 = reset asserted).
REQ-006 SHALL have port addr, input, 8, CPU data-memory address (ALU result).
REQ-007 SHALL have port wr_data, input, 8, CPU store data.
REQ-008 SHALL have port MemWrite, input, 1, CPU store strobe, one cycle per store.
REQ-009 SHALL have port MemRead, input, 1, CPU load strobe.
REQ-010 SHALL have port rd_data, output, 8, status read data.
REQ-011 SHALL have port sel, output, 1, high when addr is BASE_ADDR or BASE_ADDR+1 (CPU muxes rd_data instead of RAM).
REQ-012 SHALL have port tx, output, 1, serial line, idle high.

Function
REQ-013 SHALL push wr_data into the FIFO on the clock edge where MemWrite=1 and addr=BASE_ADDR and the FIFO is not full.
REQ-014 SHALL, if a push hits a full FIFO with no pop in the same cycle, drop the byte and set sticky overflow.
REQ-015 SHALL accept a push to a full FIFO when a pop occurs in the same cycle; occupancy is unchanged.
REQ-016 SHALL drive rd_data combinationally when MemRead=1 and addr=BASE_ADDR+1: {4'b0, overflow, busy, empty, full}; otherwise 8'h00.
REQ-017 SHALL clear overflow on the edge ending a status read, unless a new overflow occurs in the same cycle; the new overflow wins.
REQ-018 SHALL return 8'h00 for reads of BASE_ADDR and SHALL ignore writes to BASE_ADDR+1.
REQ-019 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE, or STOP -> START when the FIFO is non-empty at STOP end.
REQ-020 SHALL, in IDLE with FIFO non-empty, pop the head into an 8-bit shift register and enter START on the same edge.
REQ-021 SHALL drive tx=0 for exactly CLKS_PER_BIT cycles in START.
REQ-022 SHALL drive data bits LSB first, CLKS_PER_BIT cycles each, in DATA, using a 3-bit bit index.
REQ-023 SHALL drive tx=1 for CLKS_PER_BIT cycles in STOP; frame = 10*CLKS_PER_BIT cycles.
REQ-024 SHALL register tx so that tx goes low on the first cycle after the popping edge.
REQ-025 SHALL make the baud counter wrap from CLKS_PER_BIT-1 to 0 and reset to 0 on every state change.
REQ-026 SHALL assert busy when state is not IDLE.
REQ-027 SHALL use FIFO read/write pointers that wrap modulo FIFO_DEPTH, with a count of width log2(FIFO_DEPTH)+1.

Reset
REQ-028 SHALL, while reset=0: state IDLE, tx=1, FIFO empty (pointers and count 0), overflow=0, shift register 0, counters 0.
REQ-029 SHALL abort any frame in flight on reset assertion and drive tx=1 immediately (asynchronously).
REQ-030 SHALL return to IDLE with no frame after reset release, and SHALL NOT resume an aborted byte.

Structure
REQ-031 SHALL keep FSM state encodings and the status bit positions (FULL=0, EMPTY=1, BUSY=2, OVF=3) as named constants in a shared package also used by cpu_top.
REQ-032 SHALL use one sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count), for the FIFO.

Verification
REQ-033 SHALL cover: CLKS_PER_BIT=4, store 8'hA5 to 8'hF0 -> tx low cycles 1-4, then 1,0,1,0,0,1,0,1 (4 cycles each), high 4 cycles; busy high 40 cycles.
REQ-034 SHALL cover: 6 back-to-back stores 8'h01..8'h06 -> 8'h01..8'h05 transmitted in order with no idle gap between frames; 8'h06 dropped; status read = 8'h0C (OVF|BUSY) during frame 2.
REQ-035 SHALL cover: status read immediately after the REQ-034 overflow -> next status read has bit3=0.
REQ-036 SHALL cover: FIFO full, store on the same edge as a pop -> byte accepted and later transmitted; overflow stays 0.
REQ-037 SHALL cover: reset=0 mid-DATA of 8'hFF -> tx=1 in the same cycle, status 8'h02 after release, no residual frame.
REQ-038 SHALL cover: read of an address outside 8'hF0/8'hF1 -> sel=0, rd_data=8'h00; store to 8'hF1 -> FIFO count unchanged.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: FSM state encoding
// and status register bit positions (also consumed by cpu_top).
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_BUSY  = 2;
    localparam int unsigned STAT_OVF   = 3;

    function automatic logic [7:0] pack_status(
        input logic ovf,
        input logic busy,
        input logic empty,
        input logic full
    );
        logic [7:0] s;
        s            = '0;
        s[STAT_OVF]   = ovf;
        s[STAT_BUSY]  = busy;
        s[STAT_EMPTY] = empty;
        s[STAT_FULL]  = full;
        return s;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; pointers wrap naturally and a
// separate occupancy count drives the full/empty flags.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal when a pop frees the slot on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: CPU stores to BASE_ADDR feed a TX FIFO,
// BASE_ADDR+1 reads back {overflow, busy, empty, full}; 8N1 framing on tx.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter logic [7:0]  BASE_ADDR    = 8'hF0,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] wr_data,
    input  logic       MemWrite,
    input  logic       MemRead,
    output logic [7:0] rd_data,
    output logic       sel,
    output logic       tx
);

    import mmio_uart_tx_pkg::*;

    localparam logic [7:0]  STAT_ADDR = BASE_ADDR + 8'd1;
    localparam logic [7:0]  BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;

    tx_state_e   state_q;
    logic [7:0]  baud_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        ovf_q;
    logic        ovf_d;

    logic        wr_hit;
    logic        stat_rd;
    logic        baud_done;
    logic        busy;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [CW-1:0] fifo_count;
    logic        new_ovf;

    assign wr_hit    = MemWrite && (addr == BASE_ADDR);
    assign stat_rd   = MemRead && (addr == STAT_ADDR);
    assign baud_done = (baud_q == BAUD_LAST);
    assign busy      = (state_q != ST_IDLE);

    // Pop either to start from idle or to chain the next frame straight after a stop bit.
    assign fifo_pop  = !fifo_empty &&
                       ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_done));
    assign fifo_push = wr_hit && (!fifo_full || fifo_pop);
    assign new_ovf   = wr_hit && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (fifo_push),
        .din_i   (wr_data),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assert property (@(posedge clk) disable iff (!reset)
        ((fifo_count == '0) == fifo_empty));

    // A fresh overflow on the same edge as a status read takes priority over the clear.
    always_comb begin
        ovf_d = ovf_q;
        if (stat_rd) begin
            ovf_d = 1'b0;
        end
        if (new_ovf) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        state_q <= ST_START;
                        shift_q <= fifo_dout;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        state_q   <= ST_DATA;
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (fifo_pop) begin
                            state_q <= ST_START;
                            shift_q <= fifo_dout;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign sel     = (addr == BASE_ADDR) || (addr == STAT_ADDR);
    assign rd_data = stat_rd ? pack_status(ovf_q, busy, fifo_empty, fifo_full) : 8'h00;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboarded bench for mmio_uart_tx: a frame-level reference model predicts
// FIFO acceptance, status and the tx waveform; a serial monitor decodes frames.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       MemWrite = 1'b0;
    logic       MemRead = 1'b0;
    logic [7:0] rd_data;
    logic       sel;
    logic       tx;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .BASE_ADDR    (8'hF0),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wr_data  (wr_data),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .rd_data  (rd_data),
        .sel      (sel),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents, frame position and sticky overflow.
    logic [7:0] m_fifo[$];
    logic [7:0] sb_q[$];
    bit         m_busy = 0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_ovf = 0;

    always @(posedge clk or negedge reset) begin
        bit ends, pop, wr, full;
        if (!reset) begin
            m_fifo.delete();
            sb_q.delete();
            m_busy = 0;
            m_pos  = 0;
            m_ovf  = 0;
        end else begin
            ends = m_busy && (m_pos == FRAME - 1);
            pop  = (m_fifo.size() > 0) && (!m_busy || ends);
            wr   = MemWrite && (addr == 8'hF0);
            full = (m_fifo.size() == DEPTH);
            if (MemRead && addr == 8'hF1) m_ovf = 0;
            if (wr && full && !pop) m_ovf = 1;
            if (pop) begin
                m_byte = m_fifo.pop_front();
                m_busy = 1;
                m_pos  = 0;
            end else if (ends) begin
                m_busy = 0;
                m_pos  = 0;
            end else if (m_busy) begin
                m_pos++;
            end
            if (wr && (!full || pop)) begin
                m_fifo.push_back(wr_data);
                sb_q.push_back(wr_data);
            end
        end
    end

    function automatic logic exp_tx();
        if (!m_busy) return 1'b1;
        if (m_pos < CPB) return 1'b0;
        if (m_pos < 9 * CPB) return m_byte[m_pos / CPB - 1];
        return 1'b1;
    endfunction

    function automatic logic [7:0] exp_rd(input logic [7:0] a);
        if (a != 8'hF1) return 8'h00;
        return {4'b0, m_ovf, m_busy, m_fifo.size() == 0, m_fifo.size() == DEPTH};
    endfunction

    // Monitor: per-cycle line check plus a frame decoder feeding the scoreboard.
    bit         mon_on = 0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    bit         mon_bad = 0;

    always @(negedge clk) begin
        int idx;
        if (!reset) begin
            mon_on = 0;
        end else begin
            check("tx_line", tx, exp_tx());
            if (!mon_on) begin
                if (tx === 1'b0) begin
                    mon_on   = 1;
                    mon_cnt  = 0;
                    mon_bad  = 0;
                    mon_byte = 8'h00;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt < CPB) begin
                    if (tx !== 1'b0) mon_bad = 1;
                end else if (mon_cnt < 9 * CPB) begin
                    idx = mon_cnt / CPB - 1;
                    if (mon_cnt % CPB == 0) mon_byte[idx] = tx;
                    else if (tx !== mon_byte[idx]) mon_bad = 1;
                end else if (tx !== 1'b1) begin
                    mon_bad = 1;
                end
                if (mon_cnt == FRAME - 1) begin
                    mon_on = 0;
                    check("frame_shape", mon_bad, 0);
                    check("frame_expected", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) check("frame_byte", mon_byte, sb_q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            MemWrite = 1'b0;
            MemRead  = 1'b0;
            addr     = 8'h00;
        end
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        MemWrite = 1'b1;
        MemRead  = 1'b0;
        addr     = a;
        wr_data  = d;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        addr     = a;
        #1;
        check("sel", sel, (a == 8'hF0) || (a == 8'hF1));
        check("rd_data", rd_data, exp_rd(a));
        v = rd_data;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((m_busy || m_fifo.size() != 0) && k < budget) begin
            idle(1);
            k++;
        end
        check("drain_timeout", k < budget, 1);
        idle(2);
    endtask

    task automatic wait_pos(input int p, input bit need_full, input int budget);
        int k = 0;
        while (!(m_busy && m_pos == p && (!need_full || m_fifo.size() == DEPTH)) && k < budget) begin
            idle(1);
            k++;
        end
        check("wait_pos_timeout", k < budget, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int busy_cnt;

        // Reset state
        reset = 1'b0;
        idle(3);
        #1;
        check("reset_tx", tx, 1);
        @(negedge clk);
        reset = 1'b1;
        rd(8'hF1, v);
        check("reset_status", v, 8'h02);

        // Single byte 0xA5, busy for exactly one frame
        store(8'hF0, 8'hA5);
        busy_cnt = 0;
        for (int i = 0; i < FRAME + 4; i++) begin
            rd(8'hF1, v);
            if (v[2]) busy_cnt++;
        end
        check("busy_cycles", busy_cnt, FRAME);
        wait_drain(200);

        // Six back-to-back stores: fifth fills FIFO, sixth overflows
        for (int i = 1; i <= 6; i++) store(8'hF0, 8'(i));
        idle(45);
        rd(8'hF1, v);
        check("ovf_status", v, 8'h0C);
        rd(8'hF1, v);
        check("ovf_cleared", v[3], 0);
        wait_drain(600);

        // Store to full FIFO on the pop edge is accepted
        for (int i = 0; i < 5; i++) store(8'hF0, 8'($urandom_range(0, 255)));
        wait_pos(FRAME - 2, 1, 200);
        store(8'hF0, 8'h3C);
        rd(8'hF1, v);
        check("full_pop_status", v, 8'h05);
        wait_drain(600);

        // Address decode: foreign address, data register read, status write ignored
        rd(8'h37, v);
        check("foreign_rd", v, 8'h00);
        rd(8'hF0, v);
        check("data_reg_rd", v, 8'h00);
        store(8'hF1, 8'h99);
        rd(8'hF1, v);
        check("status_write_ignored", v, 8'h02);
        idle(5);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: store(8'hF0, 8'($urandom_range(0, 255)));
                3:       store(8'hF1, 8'($urandom_range(0, 255)));
                4, 5:    rd(8'hF1, v);
                6:       rd(8'hF0, v);
                7:       rd(8'($urandom_range(0, 255)), v);
                default: idle($urandom_range(1, 20));
            endcase
        end
        wait_drain(1000);

        // Reset during DATA of 0xFF, then during START of 0x00
        store(8'hF0, 8'hFF);
        wait_pos(3 * CPB + 1, 0, 200);
        #2 reset = 1'b0;
        #1 check("abort_data_tx", tx, 1);
        idle(3);
        reset = 1'b1;
        rd(8'hF1, v);
        check("abort_data_status", v, 8'h02);
        idle(2 * FRAME);

        store(8'hF0, 8'h00);
        store(8'hF0, 8'h81);
        wait_pos(1, 0, 200);
        #2 reset = 1'b0;
        #1 check("abort_start_tx", tx, 1);
        idle(3);
        reset = 1'b1;
        rd(8'hF1, v);
        check("abort_start_status", v, 8'h02);
        idle(2 * FRAME);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
